// File: rtl/cpu_bmem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bmem_arbiter
//
// Memory-side front end of the out-of-order cpu. Arbitrates 256-bit line
// requests from the I-cache (read only) and D-cache (read or writeback) onto
// a single burst memory port. Read bursts may come back out of order. Each
// returning burst is steered to its requester by comparing bmem_raddr with
// the table of outstanding reads.
//
// Optional feature: define MEMARB_PERF_EN to add three saturating 32-bit
// counters: perf_rd_bursts, perf_wr_bursts and perf_stall_cycles.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   i_addr/i_read       I-cache line read, held until i_resp
//   i_rdata/i_resp      returned line, one-cycle completion pulse
//   d_addr/d_read       D-cache line read, held until d_resp
//   d_write/d_wdata     D-cache writeback, held until d_resp
//   d_rdata/d_resp      returned line, one-cycle completion pulse
//   bmem_addr           burst address (line aligned)
//   bmem_read           read burst command
//   bmem_write/wdata    write beat valid / beat data
//   bmem_ready          memory accepts the command or beat this cycle
//   bmem_raddr/rdata/   returning read beats
//     rvalid
//   err                 sticky: a returning beat matched no outstanding read
//
// Handshake: a command or write beat on the port is transferred on a rising
// edge where it is presented (bmem_read or bmem_write high) and bmem_ready
// is high. Until then it is held unchanged. A new command is only chosen
// when the port is idle and bmem_ready is high. Returning beats have no
// back-pressure: every rvalid beat is consumed in the cycle it appears.
// ---------------------------------------------------------------------------
module cpu_bmem_arbiter #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32,
  localparam int LINE_W = DATA_W * BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [DATA_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [DATA_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid,
  output logic              err
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0]       perf_rd_bursts,
  output logic [31:0]       perf_wr_bursts,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

  // ST_RD_CMD holds bmem_read until the memory takes it.
  // ST_WR_BURST locks the port for the whole writeback.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_CMD   = 2'd1,
    ST_WR_BURST = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  // Per-client bookkeeping. "issued" blocks re-issue until the resp cycle.
  // The entry tables describe reads that are waiting for data.
  logic              i_issued_q, i_issued_nxt;
  logic              d_issued_q, d_issued_nxt;
  logic              i_ent_vld_q, i_ent_vld_nxt;
  logic              d_ent_vld_q, d_ent_vld_nxt;
  logic [ADDR_W-1:0] i_ent_addr_q, i_ent_addr_nxt;
  logic [ADDR_W-1:0] d_ent_addr_q, d_ent_addr_nxt;
  logic              rr_d_q, rr_d_nxt;     // 1: D wins a tie
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_nxt;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_nxt;

  logic [LINE_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              i_resp_nxt, d_resp_nxt;
  logic [ADDR_W-1:0] bmem_addr_nxt;
  logic              bmem_read_nxt, bmem_write_nxt;
  logic [DATA_W-1:0] bmem_wdata_nxt;
  logic              err_nxt;

  logic [ADDR_W-1:0] i_line, d_line, r_line;
  logic              i_cand, d_cand, grant_i, grant_d;
  logic              hit_i, hit_d;

  assign i_line = i_addr & LINE_MASK;
  assign d_line = d_addr & LINE_MASK;
  assign r_line = bmem_raddr & LINE_MASK;

  // A read to the line the other client is still waiting on is held back.
  // This keeps every raddr matching at most one entry.
  assign i_cand = i_read && !i_issued_q &&
                  !(d_ent_vld_q && (d_ent_addr_q == i_line));
  assign d_cand = !d_issued_q &&
                  (d_write || (d_read && !(i_ent_vld_q && (i_ent_addr_q == d_line))));

  assign grant_d = (state_q == ST_IDLE) && bmem_ready && d_cand && (!i_cand || rr_d_q);
  assign grant_i = (state_q == ST_IDLE) && bmem_ready && i_cand && !grant_d;

  assign hit_i = bmem_rvalid && i_ent_vld_q && (i_ent_addr_q == r_line);
  assign hit_d = bmem_rvalid && d_ent_vld_q && (d_ent_addr_q == r_line);

  always_comb begin
    state_nxt      = state_q;
    i_issued_nxt   = i_issued_q;
    d_issued_nxt   = d_issued_q;
    i_ent_vld_nxt  = i_ent_vld_q;
    d_ent_vld_nxt  = d_ent_vld_q;
    i_ent_addr_nxt = i_ent_addr_q;
    d_ent_addr_nxt = d_ent_addr_q;
    rr_d_nxt       = rr_d_q;
    ret_cnt_nxt    = ret_cnt_q;
    wr_cnt_nxt     = wr_cnt_q;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_resp_nxt     = 1'b0;
    d_resp_nxt     = 1'b0;
    bmem_addr_nxt  = bmem_addr;
    bmem_read_nxt  = bmem_read;
    bmem_write_nxt = bmem_write;
    bmem_wdata_nxt = bmem_wdata;
    err_nxt        = err;

    // The requester still holds its request during the resp cycle, so the
    // issued flag is only dropped at the end of that cycle.
    if (i_resp) i_issued_nxt = 1'b0;
    if (d_resp) d_issued_nxt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          bmem_read_nxt  = 1'b1;
          bmem_addr_nxt  = i_line;
          i_issued_nxt   = 1'b1;
          i_ent_vld_nxt  = 1'b1;
          i_ent_addr_nxt = i_line;
          rr_d_nxt       = 1'b1;
          state_nxt      = ST_RD_CMD;
        end else if (grant_d) begin
          bmem_addr_nxt = d_line;
          d_issued_nxt  = 1'b1;
          rr_d_nxt      = 1'b0;
          if (d_write) begin
            bmem_write_nxt = 1'b1;
            bmem_wdata_nxt = d_wdata[DATA_W-1:0];
            wr_cnt_nxt     = '0;
            state_nxt      = ST_WR_BURST;
          end else begin
            bmem_read_nxt  = 1'b1;
            d_ent_vld_nxt  = 1'b1;
            d_ent_addr_nxt = d_line;
            state_nxt      = ST_RD_CMD;
          end
        end
      end

      ST_RD_CMD: begin
        if (bmem_ready) begin
          bmem_read_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end

      ST_WR_BURST: begin
        if (bmem_ready) begin
          if (wr_cnt_q == LAST_BEAT) begin
            bmem_write_nxt = 1'b0;
            d_resp_nxt     = 1'b1;
            state_nxt      = ST_IDLE;
          end else begin
            wr_cnt_nxt = wr_cnt_q + 1'b1;
            for (int k = 0; k < BEATS; k++) begin
              if (CNT_W'(k) == wr_cnt_nxt) bmem_wdata_nxt = d_wdata[k*DATA_W +: DATA_W];
            end
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Return path runs independently of the issue side. Bursts are not
    // interleaved, so one beat counter serves both clients.
    if (hit_i || hit_d) begin
      for (int k = 0; k < BEATS; k++) begin
        if (CNT_W'(k) == ret_cnt_q) begin
          if (hit_i) i_rdata_nxt[k*DATA_W +: DATA_W] = bmem_rdata;
          else       d_rdata_nxt[k*DATA_W +: DATA_W] = bmem_rdata;
        end
      end
      if (ret_cnt_q == LAST_BEAT) begin
        ret_cnt_nxt = '0;
        if (hit_i) begin
          i_resp_nxt    = 1'b1;
          i_ent_vld_nxt = 1'b0;
        end else begin
          d_resp_nxt    = 1'b1;
          d_ent_vld_nxt = 1'b0;
        end
      end else begin
        ret_cnt_nxt = ret_cnt_q + 1'b1;
      end
    end else if (bmem_rvalid) begin
      err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      i_issued_q   <= 1'b0;
      d_issued_q   <= 1'b0;
      i_ent_vld_q  <= 1'b0;
      d_ent_vld_q  <= 1'b0;
      i_ent_addr_q <= '0;
      d_ent_addr_q <= '0;
      rr_d_q       <= 1'b1;
      ret_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
      bmem_addr    <= '0;
      bmem_read    <= 1'b0;
      bmem_write   <= 1'b0;
      bmem_wdata   <= '0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      i_issued_q   <= i_issued_nxt;
      d_issued_q   <= d_issued_nxt;
      i_ent_vld_q  <= i_ent_vld_nxt;
      d_ent_vld_q  <= d_ent_vld_nxt;
      i_ent_addr_q <= i_ent_addr_nxt;
      d_ent_addr_q <= d_ent_addr_nxt;
      rr_d_q       <= rr_d_nxt;
      ret_cnt_q    <= ret_cnt_nxt;
      wr_cnt_q     <= wr_cnt_nxt;
      i_rdata      <= i_rdata_nxt;
      d_rdata      <= d_rdata_nxt;
      i_resp       <= i_resp_nxt;
      d_resp       <= d_resp_nxt;
      bmem_addr    <= bmem_addr_nxt;
      bmem_read    <= bmem_read_nxt;
      bmem_write   <= bmem_write_nxt;
      bmem_wdata   <= bmem_wdata_nxt;
      err          <= err_nxt;
    end
  end

`ifdef MEMARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_rd_bursts    <= '0;
      perf_wr_bursts    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((grant_i || (grant_d && !d_write)) && (perf_rd_bursts != '1))
        perf_rd_bursts <= perf_rd_bursts + 32'd1;
      if ((state_q == ST_WR_BURST) && bmem_ready && (wr_cnt_q == LAST_BEAT) &&
          (perf_wr_bursts != '1))
        perf_wr_bursts <= perf_wr_bursts + 32'd1;
      if ((i_cand || d_cand) && !bmem_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_bmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_bmem_arbiter
//
// Bench for cpu_bmem_arbiter. A monitor on the falling edge compares every
// burst command, write beat and completion pulse against expected queues
// filled by the stimulus tasks. A table of single reads is followed by
// hand-written sequences for the multi-cycle cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_bmem_arbiter;
  localparam int DATA_W = 64;
  localparam int BEATS  = 4;
  localparam int ADDR_W = 32;
  localparam int LINE_W = DATA_W * BEATS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] i_addr, d_addr, bmem_addr, bmem_raddr;
  logic              i_read, i_resp, d_read, d_write, d_resp;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata;
  logic              bmem_read, bmem_write, bmem_ready, bmem_rvalid, err;
  logic [DATA_W-1:0] bmem_wdata, bmem_rdata;

  cpu_bmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_rd_pulse = 0;
  int exp_dw_n = 0;
  logic [ADDR_W-1:0] exp_wr_addr = '0;
  logic [ADDR_W-1:0] exp_cmd_q[$];
  logic [DATA_W-1:0] exp_wr_q[$];
  logic [LINE_W-1:0] exp_i_q[$];
  logic [LINE_W-1:0] exp_d_q[$];

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag_fail(input string nm, input string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", nm, why);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bmem_read && bmem_ready) begin
        n_rd_pulse++;
        if (exp_cmd_q.size() == 0) flag_fail("bmem_read", $sformatf("unexpected burst at %h", bmem_addr));
        else chk("bmem_read_addr", LINE_W'(bmem_addr), LINE_W'(exp_cmd_q.pop_front()));
      end
      if (bmem_write && bmem_ready) begin
        if (exp_wr_q.size() == 0) flag_fail("bmem_write", "unexpected write beat");
        else begin
          chk("bmem_wdata", LINE_W'(bmem_wdata), LINE_W'(exp_wr_q.pop_front()));
          chk("bmem_wr_addr", LINE_W'(bmem_addr), LINE_W'(exp_wr_addr));
        end
      end
      if (i_resp) begin
        if (exp_i_q.size() == 0) flag_fail("i_resp", "unexpected completion pulse");
        else chk("i_rdata", i_rdata, exp_i_q.pop_front());
      end
      if (d_resp) begin
        if (d_write) begin
          if (exp_dw_n == 0) flag_fail("d_resp_wr", "unexpected write completion");
          else begin
            exp_dw_n--;
            n_tests++;
          end
        end else if (exp_d_q.size() == 0) flag_fail("d_resp", "unexpected completion pulse");
        else chk("d_rdata", d_rdata, exp_d_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int k = 0; k < LINE_W / 32; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic wait_issues(input int target, input string nm);
    for (int c = 0; c < 30 && n_rd_pulse < target; c++) cyc();
    if (n_rd_pulse < target) flag_fail(nm, "bmem_read not seen within 30 cycles");
  endtask

  task automatic send_burst(input logic [ADDR_W-1:0] ra, input logic [LINE_W-1:0] line);
    for (int k = 0; k < BEATS; k++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = ra;
      bmem_rdata  = line[k*DATA_W +: DATA_W];
      cyc();
    end
    bmem_rvalid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_d, input string nm);
    bit seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (is_d ? d_resp : i_resp) seen = 1'b1;
      else cyc();
    end
    if (!seen) flag_fail(nm, "no completion pulse within 30 cycles");
    @(negedge clk);
    #1;
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  task automatic do_read(input bit is_d, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] ra,
                         input logic [ADDR_W-1:0] ea, input logic [LINE_W-1:0] line);
    int base = n_rd_pulse;
    exp_cmd_q.push_back(ea);
    if (is_d) begin
      exp_d_q.push_back(line);
      d_addr = a;
      d_read = 1'b1;
    end else begin
      exp_i_q.push_back(line);
      i_addr = a;
      i_read = 1'b1;
    end
    wait_issues(base + 1, "read_issue");
    send_burst(ra, line);
    wait_resp(is_d, "read_resp");
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit                is_d;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] line;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #300000;
    flag_fail("global_timeout", "simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    logic [LINE_W-1:0] l_a, l_b, w_line;
    int  base;
    bit  seen;
    bit  first_d;

    vecs[0] = '{1'b0, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{1'b1, 32'h0000_2A3F, 32'h0000_2A20, 32'h0000_2A20, rand_line()};
    vecs[2] = '{1'b0, 32'h0000_0004, 32'h0000_001C, 32'h0000_0000, rand_line()};
    vecs[3] = '{1'b1, 32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_FFE0, {LINE_W{1'b1}}};
    vecs[4] = '{1'b0, 32'h8765_4321, 32'h8765_4320, 32'h8765_4320, rand_line()};
    vecs[5] = '{1'b1, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, rand_line()};

    rst = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (3) cyc();

    // reset state
    chk("rst_bmem_cmd", LINE_W'({bmem_read, bmem_write, bmem_addr, bmem_wdata}), '0);
    chk("rst_resp_err", LINE_W'({i_resp, d_resp, err}), '0);
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    rst = 1'b1;
    cyc();

    // simultaneous I 0x1000 / D 0x3000: D first after reset, memory returns D first
    l_a = rand_line();
    l_b = rand_line();
    base = n_rd_pulse;
    exp_cmd_q.push_back(32'h0000_3000);
    exp_cmd_q.push_back(32'h0000_1000);
    exp_d_q.push_back(l_a);
    exp_i_q.push_back(l_b);
    i_addr = 32'h0000_1000; d_addr = 32'h0000_3000;
    i_read = 1'b1; d_read = 1'b1;
    wait_issues(base + 2, "conc_issue");
    send_burst(32'h0000_3000, l_a);
    chk("conc_i_not_yet", LINE_W'(i_resp), '0);
    wait_resp(1'b1, "conc_d_resp");
    send_burst(32'h0000_1000, l_b);
    wait_resp(1'b0, "conc_i_resp");
    chk("conc_err", LINE_W'(err), '0);

    // table of single reads
    for (int v = 0; v < 6; v++)
      do_read(vecs[v].is_d, vecs[v].addr, vecs[v].raddr, vecs[v].exp_addr, vecs[v].line);

    // writeback with a two-cycle stall after beat 1
    w_line = rand_line();
    exp_wr_addr = 32'h0000_2040;
    for (int k = 0; k < BEATS; k++) exp_wr_q.push_back(w_line[k*DATA_W +: DATA_W]);
    exp_dw_n++;
    d_addr = 32'h0000_2040; d_wdata = w_line; d_write = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (bmem_write) seen = 1'b1;
      else cyc();
    end
    if (!seen) flag_fail("wr_start", "no write beat within 30 cycles");
    chk("wr_beat0", LINE_W'(bmem_wdata), LINE_W'(w_line[63:0]));
    cyc();
    chk("wr_beat1", LINE_W'(bmem_wdata), LINE_W'(w_line[127:64]));
    cyc();
    bmem_ready = 1'b0;
    cyc();
    chk("wr_stall_hold1", LINE_W'({bmem_write, bmem_wdata}), LINE_W'({1'b1, w_line[191:128]}));
    cyc();
    chk("wr_stall_hold2", LINE_W'({bmem_write, bmem_wdata}), LINE_W'({1'b1, w_line[191:128]}));
    chk("wr_stall_addr", LINE_W'(bmem_addr), LINE_W'(32'h0000_2040));
    bmem_ready = 1'b1;
    cyc();
    chk("wr_beat3", LINE_W'(bmem_wdata), LINE_W'(w_line[255:192]));
    chk("wr_no_resp_yet", LINE_W'(d_resp), '0);
    cyc();
    chk("wr_d_resp", LINE_W'({d_resp, bmem_write}), LINE_W'(2'b10));
    @(negedge clk);
    #1;
    d_write = 1'b0;

    // same line from both clients: one burst at a time
    l_a = rand_line();
    base = n_rd_pulse;
    exp_cmd_q.push_back(32'h0000_4000);
    exp_cmd_q.push_back(32'h0000_4000);
    exp_i_q.push_back(l_a);
    exp_d_q.push_back(l_a);
    i_addr = 32'h0000_4000; d_addr = 32'h0000_4000;
    i_read = 1'b1; d_read = 1'b1;
    wait_issues(base + 1, "hazard_first_issue");
    repeat (6) cyc();
    chk("hazard_single_issue", LINE_W'(n_rd_pulse), LINE_W'(base + 1));
    send_burst(32'h0000_4000, l_a);
    chk("hazard_first_resp", LINE_W'(i_resp ^ d_resp), LINE_W'(1'b1));
    first_d = d_resp;
    @(negedge clk);
    #1;
    if (first_d) d_read = 1'b0;
    else i_read = 1'b0;
    wait_issues(base + 2, "hazard_second_issue");
    send_burst(32'h0000_4000, l_a);
    wait_resp(!first_d, "hazard_second_resp");

    // unmatched return
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_9000; bmem_rdata = 64'hDEAD_BEEF_0000_0001;
    cyc();
    bmem_rvalid = 1'b0;
    chk("err_set", LINE_W'(err), LINE_W'(1'b1));
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk("err_sticky", LINE_W'(err), LINE_W'(1'b1));
    end
    rst = 1'b0;
    cyc();
    chk("err_cleared", LINE_W'(err), '0);
    rst = 1'b1;
    cyc();

    // reset in the middle of a writeback
    w_line = rand_line();
    exp_wr_addr = 32'h0000_6000;
    for (int k = 0; k < BEATS; k++) exp_wr_q.push_back(w_line[k*DATA_W +: DATA_W]);
    d_addr = 32'h0000_6000; d_wdata = w_line; d_write = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (bmem_write) seen = 1'b1;
      else cyc();
    end
    if (!seen) flag_fail("rstwr_start", "no write beat within 30 cycles");
    cyc();
    rst = 1'b0;
    d_write = 1'b0;
    cyc();
    chk("rstwr_bmem_write", LINE_W'(bmem_write), '0);
    chk("rstwr_outputs", LINE_W'({bmem_read, bmem_addr, bmem_wdata, i_resp, d_resp, err}), '0);
    chk("rstwr_d_rdata", d_rdata, '0);
    chk("rstwr_i_rdata", i_rdata, '0);
    exp_wr_q.delete();
    rst = 1'b1;
    cyc();
    do_read(1'b1, 32'h0000_5000, 32'h0000_5000, 32'h0000_5000, rand_line());
    do_read(1'b0, 32'h0000_2040, 32'h0000_2040, 32'h0000_2040, rand_line());

    repeat (3) cyc();
    chk("final_err", LINE_W'(err), '0);
    chk("cmd_q_drained", LINE_W'(exp_cmd_q.size()), '0);
    chk("i_q_drained", LINE_W'(exp_i_q.size()), '0);
    chk("d_q_drained", LINE_W'(exp_d_q.size()), '0);
    chk("wr_done_drained", LINE_W'(exp_dw_n), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bmem_arbiter.md
Name: cpu_bmem_arbiter

Overview:
- Memory-side front end of the out-of-order `cpu`.
- Arbitrates 256-bit cache-line requests from the I-cache (read only) and D-cache (read/write) onto the banked burst memory port.
- Burst port signals: bmem_addr/read/write/wdata/ready/raddr/rdata/rvalid.
- The FR-FCFS DRAM controller behind the port can return read bursts out of order; responses are matched to requesters by bmem_raddr.

Parameters:
- DATA_W, 64, width of one burst beat.
- BEATS, 4, beats per burst; line width LINE_W = DATA_W*BEATS = 256.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset (rst=0 resets on rising clk).
- i_addr  in  ADDR_W  I-cache line address.
- i_read  in  1  I-cache read request; held until i_resp.
- i_rdata  out  LINE_W  returned line.
- i_resp  out  1  one-cycle completion pulse.
- d_addr  in  ADDR_W  D-cache line address.
- d_read  in  1  D-cache read request; held until d_resp.
- d_write  in  1  D-cache writeback request; held until d_resp; never asserted together with d_read.
- d_wdata  in  LINE_W  writeback line; stable while d_write is high.
- d_rdata  out  LINE_W  returned line.
- d_resp  out  1  one-cycle completion pulse (read or write).
- bmem_addr  out  ADDR_W  burst address, low 5 bits forced to 0.
- bmem_read  out  1  read burst issue.
- bmem_write  out  1  write beat valid.
- bmem_wdata  out  DATA_W  write beat.
- bmem_ready  in  1  memory accepts a command/beat this cycle.
- bmem_raddr  in  ADDR_W  address of the returning burst.
- bmem_rdata  in  DATA_W  returning beat.
- bmem_rvalid  in  1  returning beat valid.
- err  out  1  sticky: rvalid whose raddr matches no outstanding read.

Behaviour:
Reset:
- All outputs 0; outstanding tables, beat counters and round-robin pointer cleared.
- Reset mid-burst abandons the operation.
- Late returns after reset are discarded and set err.

Read issue:
- bmem_read high for exactly one cycle, with bmem_addr, in a cycle where bmem_ready=1 and the port is not mid-write.
- On issue, record {valid, line address} for that client; its request is then marked issued.
- No re-issue until that client's resp.

Write issue:
- BEATS consecutive accepted beats, bmem_write=1, bmem_addr held constant.
- Beat k drives d_wdata[k*DATA_W +: DATA_W]; beat 0 = bits [63:0].
- The beat counter advances only when bmem_ready=1; when ready=0, current beat and address are held.
- d_resp pulses the cycle after the final beat is accepted.
- Writes are posted: no read-outstanding check is applied.

Arbitration (port idle, ready=1):
- Candidates: unissued i_read, and unissued d_read or d_write.
- Single candidate: that candidate wins.
- Both candidates: round-robin; pointer starts at D and flips to the loser after each grant.
- Each grant is one command; the port is locked for the whole write burst.

Address hazard:
- A read whose line address equals the other client's outstanding read address is held (not issued) until that read completes.
- Hence raddr matches at most one entry.

Read return:
- On rvalid, compare raddr (line-aligned) with both outstanding entries.
- On a match, beat n is written into the line buffer at [n*DATA_W +: DATA_W].
- After BEATS beats the client's xx_resp pulses in the same cycle as the last beat is registered, i.e. xx_rdata is valid the cycle after the last rvalid, with xx_resp high in that cycle.
- The entry is then cleared.
- Beats of one burst are consecutive; interleaving between bursts is not supported.
- A new issue may overlap a return; return and issue in the same cycle are independent.

Latency:
- Idle port, ready=1: request seen in cycle 0, bmem_read or the first write beat in cycle 1 (registered outputs).

Optional Feature:
- Macro MEMARB_PERF_EN.
- Defined: adds outputs perf_rd_bursts (32), perf_wr_bursts (32) and perf_stall_cycles (32). They count issued read bursts, completed write bursts, and cycles with a pending candidate while bmem_ready=0. Counters saturate at 0xFFFFFFFF and are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- I-read 0x00001000, ready=1, memory returns 4 beats 0x11..,0x22..,0x33..,0x44.. with raddr 0x1000 -> one bmem_read pulse at addr 0x1000; i_resp once with i_rdata = {0x44..,0x33..,0x22..,0x11..}.
- D-write 0x00002040, wdata words W0..W3, bmem_ready dropped for 2 cycles after beat 1 -> 4 write beats in order W0..W3, beat 2 held during the stall, addr 0x2040 throughout; d_resp one cycle after beat 3.
- I-read 0x1000 and D-read 0x3000 in the same cycle, memory returns 0x3000 first -> D issued first (reset pointer); d_resp fires before i_resp with correct data; err=0.
- I-read and D-read both to 0x4000 -> only one bmem_read until the first resp completes; the second is issued afterwards; both receive the line.
- rvalid with raddr 0x9000 and no outstanding read -> err=1 and sticky until rst=0; no resp pulse.
- Mid-write-burst rst=0 for one cycle -> bmem_write=0 next cycle; all outputs 0; new request serviced normally afterwards.
